// File: rtl/load_store_unit.sv
// Data-memory stage: one load/store per start; loads and word stores take 2+W cycles, sub-word stores take 4+ (read-modify-write).
// Memory is req/ack with a TIMEOUT abort; start is ignored while busy, so the control FSM must wait for done.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WAIT,
        RMW_READ,
        MERGE,
        STORE_WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [2:0]  funct3Q;
    logic [1:0]  byteOff;
    logic [15:0] wdataQ;
    logic [31:0] readWord;
    logic [7:0]  waitCnt;
    logic        errQ;
    logic        legalCode;
    logic        misaligned;
    logic        accessOk;
    logic        ackSeen;
    logic        timedOut;

    function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extendLoad = {{24{b[7]}}, b};
            3'b001:  extendLoad = {{16{h[15]}}, h};
            3'b100:  extendLoad = {24'b0, b};
            3'b101:  extendLoad = {16'b0, h};
            default: extendLoad = w;
        endcase
    endfunction

    function automatic logic [31:0] mergeStore(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] old, input logic [15:0] wd);
        logic [31:0] r;
        r = old;
        if (f3[0]) begin
            if (off[1]) r[31:16] = wd;
            else        r[15:0]  = wd;
        end else begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end
        mergeStore = r;
    endfunction

    assign legalCode  = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // funct3[1:0] selects width for both signed and unsigned loads
    assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                        (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign accessOk   = legalCode && !misaligned;

    assign mem_req  = (state == LOAD_WAIT) || (state == RMW_READ) || (state == STORE_WAIT);
    assign ackSeen  = mem_req && mem_ack;
    assign timedOut = mem_req && !mem_ack && (waitCnt == 8'(TIMEOUT - 1));
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = done && errQ;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!accessOk)              nextState = DONE;
                    else if (!is_store)         nextState = LOAD_WAIT;
                    else if (funct3 == 3'b010)  nextState = STORE_WAIT;
                    else                        nextState = RMW_READ;
                end
            end
            LOAD_WAIT:  if (ackSeen || timedOut) nextState = DONE;
            RMW_READ: begin
                if (ackSeen)       nextState = MERGE;
                else if (timedOut) nextState = DONE;
            end
            MERGE:      nextState = STORE_WAIT;
            STORE_WAIT: if (ackSeen || timedOut) nextState = DONE;
            DONE:       nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            funct3Q   <= '0;
            byteOff   <= '0;
            wdataQ    <= '0;
            readWord  <= '0;
            waitCnt   <= '0;
            errQ      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            load_data <= '0;
        end else begin
            state   <= nextState;
            // counts cycles of the current transaction; any state change restarts it
            waitCnt <= (mem_req && nextState == state) ? waitCnt + 8'd1 : 8'd0;
            case (state)
                IDLE: begin
                    if (start) begin
                        funct3Q   <= funct3;
                        byteOff   <= addr[1:0];
                        wdataQ    <= wdata[15:0];
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= wdata;
                        mem_we    <= accessOk && is_store && (funct3 == 3'b010);
                        errQ      <= !accessOk;
                        if (!accessOk) load_data <= '0;
                    end
                end
                LOAD_WAIT: begin
                    if (ackSeen) begin
                        load_data <= extendLoad(funct3Q, byteOff, mem_rdata);
                    end else if (timedOut) begin
                        load_data <= '0;
                        errQ      <= 1'b1;
                    end
                end
                RMW_READ: begin
                    if (ackSeen)       readWord <= mem_rdata;
                    else if (timedOut) errQ     <= 1'b1;
                end
                MERGE: begin
                    mem_wdata <= mergeStore(funct3Q, byteOff, readWord, wdataQ);
                    mem_we    <= 1'b1;
                end
                STORE_WAIT: if (timedOut) errQ <= 1'b1;
                DONE:       mem_we <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scripted word memory answers req/ack with a per-access wait count,
// and each access pushes its expected done cycle / err / load_data to a scoreboard popped on done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    load_store_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          doneCyc;
        logic        errExp;
        logic [31:0] dataExp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [logic [29:0]];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          doneCnt = 0;
    int          reqRun = 0;
    int          ackAfter = -1;
    int          writeCount = 0;
    int          lastWriteCyc = 0;
    logic [31:0] lastWrite = '0;
    logic [31:0] reqMask = '0;
    logic        gotDone = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: observe outputs on the falling edge, then answer the memory request for the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        if (cyc < 32) reqMask[cyc] = mem_req;
        if (done) begin
            doneCnt++;
            gotDone = 1'b1;
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.doneCyc));
                check({e.tag, "_err"}, 32'(err), 32'(e.errExp));
                check({e.tag, "_data"}, load_data, e.dataExp);
            end
        end
        if (mem_req) begin
            reqRun++;
            if (ackAfter >= 0 && reqRun == ackAfter + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : 32'h0;
                if (mem_we) begin
                    mem[mem_addr[31:2]] = mem_wdata;
                    lastWrite    = mem_wdata;
                    lastWriteCyc = cyc;
                    writeCount++;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEADBEEF;
            end
        end else begin
            reqRun  = 0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ackW);
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        ackAfter = ackW;
        cyc      = 0;
        reqMask  = '0;
        gotDone  = 1'b0;
    endtask

    task automatic issue(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ackW, input int expCyc, input logic expErr,
                         input logic [31:0] expData);
        exp_t e;
        e.tag     = tag;
        e.doneCyc = expCyc;
        e.errExp  = expErr;
        e.dataExp = expData;
        sb.push_back(e);
        drive(st, f3, a, wd, ackW);
    endtask

    // Waits (bounded) for done, then one more cycle so the unit is back in IDLE.
    task automatic complete(input string tag, input logic [31:0] expMask);
        int n = 0;
        while (!gotDone && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_finished"}, 32'(gotDone), 32'd1);
        tick();
        check({tag, "_req_cycles"}, reqMask, expMask);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int wc;
        int dc;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        check("rst_ctrl", 32'({busy, done, err, mem_req, mem_we}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_ctrl", 32'({busy, done, mem_req}), 32'd0);

        // Loads from 0x80FF7F01 with extension
        mem[30'h40] = 32'h80FF7F01;
        issue("lb_102", 0, 3'b000, 32'h102, 0, 0, 2, 0, 32'hFFFFFFFF);  complete("lb_102", 32'h2);
        issue("lbu_102", 0, 3'b100, 32'h102, 0, 0, 2, 0, 32'h000000FF); complete("lbu_102", 32'h2);
        issue("lb_103", 0, 3'b000, 32'h103, 0, 0, 2, 0, 32'hFFFFFF80);  complete("lb_103", 32'h2);
        issue("lh_102", 0, 3'b001, 32'h102, 0, 0, 2, 0, 32'hFFFF80FF);  complete("lh_102", 32'h2);
        issue("lhu_102", 0, 3'b101, 32'h102, 0, 0, 2, 0, 32'h000080FF); complete("lhu_102", 32'h2);
        issue("lw_w3", 0, 3'b010, 32'h100, 0, 3, 5, 0, 32'h80FF7F01);   complete("lw_w3", 32'h1E);

        // Sub-word stores via read-modify-write; load_data untouched by stores
        mem[30'h40] = 32'h11223344;
        issue("sb_101", 1, 3'b000, 32'h101, 32'h000000AB, 0, 4, 0, 32'h80FF7F01);
        complete("sb_101", 32'hA);
        check("sb_101_wdata", lastWrite, 32'h1122AB44);
        check("sb_101_wcycle", 32'(lastWriteCyc), 32'd3);
        mem[30'h40] = 32'h11223344;
        issue("sh_102", 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 4, 0, 32'h80FF7F01);
        complete("sh_102", 32'hA);
        check("sh_102_mem", mem[30'h40], 32'hBEEF3344);
        issue("sw_104", 1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 2, 0, 32'h80FF7F01);
        complete("sw_104", 32'h2);
        check("sw_104_mem", mem[30'h41], 32'hCAFEF00D);
        check("sw_104_wcycle", 32'(lastWriteCyc), 32'd1);

        // Illegal and misaligned accesses
        wc = writeCount;
        issue("lw_misal", 0, 3'b010, 32'h102, 0, 0, 1, 1, 32'h0);        complete("lw_misal", 32'h0);
        issue("ld_f3_011", 0, 3'b011, 32'h100, 0, 0, 1, 1, 32'h0);       complete("ld_f3_011", 32'h0);
        issue("st_f3_100", 1, 3'b100, 32'h100, 32'h55, 0, 1, 1, 32'h0);  complete("st_f3_100", 32'h0);
        check("illegal_no_write", 32'(writeCount), 32'(wc));

        // Timeout boundary: ack in the 15th request cycle still succeeds
        mem[30'h40] = 32'h80FF7F01;
        issue("lw_ack15", 0, 3'b010, 32'h100, 0, 14, 16, 0, 32'h80FF7F01); complete("lw_ack15", 32'hFFFE);
        issue("lw_tmo", 0, 3'b010, 32'h100, 0, -1, 16, 1, 32'h0);          complete("lw_tmo", 32'hFFFE);
        wc = writeCount;
        issue("sb_tmo", 1, 3'b000, 32'h100, 32'h77, -1, 16, 1, 32'h0);     complete("sb_tmo", 32'hFFFE);
        check("sb_tmo_no_write", 32'(writeCount), 32'(wc));

        // Reset during STORE_WAIT aborts without done
        dc = doneCnt;
        drive(1, 3'b010, 32'h108, 32'h12345678, -1);
        tick(); tick();
        check("pre_rst_busy", 32'({busy, mem_req}), 32'd3);
        rst = 1'b1;
        tick();
        check("post_rst_req", 32'(mem_req), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("rst_no_done", 32'(doneCnt), 32'(dc));

        // start pulsed while the load is waiting is ignored
        dc = doneCnt;
        issue("lw_restart", 0, 3'b010, 32'h100, 0, 3, 5, 0, 32'h80FF7F01);
        tick(); tick();
        start = 1'b1; funct3 = 3'b000; addr = 32'h103;
        complete("lw_restart", 32'h1E);
        repeat (8) tick();
        check("restart_one_done", 32'(doneCnt - dc), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
